// File: rtl/ifetch.sv
// Instruction fetch unit: holds the PC, issues word reads to a one-cycle
// latency instruction memory and buffers returned words in a 2-entry queue
// whose head is presented to decode under a valid/ready handshake.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  occ_q, occ_d;
    // Slot 0 is always the queue head and drives the decode outputs directly.
    logic [31:0] q_pc_q   [2];
    logic [31:0] q_word_q [2];
    logic [31:0] q_pc_d   [2];
    logic [31:0] q_word_d [2];

    logic        pop;
    logic        push;
    logic [2:0]  credit;
    logic [1:0]  occ_after_pop;

    assign ins_valid = (occ_q != 2'd0);
    assign ins       = q_word_q[0];
    assign ins_pc    = q_pc_q[0];
    assign imem_addr = fetch_pc_q;

    // Handshake, credit check and request generation; a request is only
    // issued when the word it returns is guaranteed a free queue slot.
    always_comb begin
        pop      = ins_valid & ins_ready & ~redirect;
        push     = inflight_q & ~redirect;
        credit   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        imem_req = ~rst & ~redirect & (credit < 3'd2);
    end

    // Next state for PC, in-flight tracking and the shifting queue.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = inflight_pc_q;
        q_pc_d        = q_pc_q;
        q_word_d      = q_word_q;
        occ_after_pop = occ_q;

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (imem_req) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
        end

        // Popping shifts slot 1 into the head; a push then lands behind
        // whatever remains (credit keeps occ_after_pop at 0 or 1 here).
        if (pop) begin
            q_pc_d[0]     = q_pc_q[1];
            q_word_d[0]   = q_word_q[1];
            occ_after_pop = occ_q - 2'd1;
        end
        if (push) begin
            q_pc_d[occ_after_pop[0]]   = inflight_pc_q;
            q_word_d[occ_after_pop[0]] = imem_rdata;
        end

        occ_d = occ_after_pop + {1'b0, push};
        if (redirect) begin
            occ_d = 2'd0;
        end
    end

    // State registers with synchronous reset; reset drops queued and
    // in-flight words exactly like a redirect to RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            occ_q         <= 2'd0;
            q_pc_q[0]     <= 32'd0;
            q_pc_q[1]     <= 32'd0;
            q_word_q[0]   <= 32'd0;
            q_word_q[1]   <= 32'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            occ_q         <= occ_d;
            q_pc_q        <= q_pc_d;
            q_word_q      <= q_word_d;
        end
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit that produces the 32-bit instruction word consumed by the decode stage. It holds the PC, issues word reads to a synchronous instruction memory with one-cycle read latency, and buffers returned words in a 2-entry queue. The head of the queue is presented to decode under a valid/ready handshake. A redirect input (jump/branch) flushes all fetched and in-flight words and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request this cycle; memory always accepts.
- imem_addr  out  32  word address of the request (= fetch_pc).
- imem_rdata  in  32  read data, valid exactly one cycle after an accepted imem_req.
- ins  out  32  instruction at queue head, to decode `ins`.
- ins_pc  out  32  PC of `ins`.
- ins_valid  out  1  queue non-empty.
- ins_ready  in  1  decode accepts `ins` this cycle.
- redirect  in  1  single-cycle pulse; kill all fetched and in-flight words.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 0.

## Operation
- State: fetch_pc[31:0]; inflight (1 bit) plus inflight_pc[31:0]; 2-entry queue of {pc, word} with occupancy occ (0..2).
- pop = ins_valid & ins_ready & ~redirect.
- imem_req = ~rst & ~redirect & ((occ + inflight − pop) < 2). This path is combinational from ins_ready and redirect.
- On imem_req:
  - fetch_pc <= fetch_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - inflight <= 1 and inflight_pc <= fetch_pc.
  - Otherwise inflight <= 0.
- Response: when inflight = 1 and no redirect, push {inflight_pc, imem_rdata} at the queue tail this cycle.
- Credit rule: the request condition guarantees the queue never overflows, so push and pop in the same cycle are both honoured.
- Output: ins, ins_pc, and ins_valid are registered from the queue head. Order is strictly program order.
- Redirect has priority over all other events in the same cycle:
  - occ <= 0 and inflight <= 0; the response arriving next cycle is discarded.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No request is issued that cycle.
  - A concurrent ins_valid & ins_ready is not a transfer; decode treats it as killed.
- Reset:
  - fetch_pc <= RESET_PC.
  - occ <= 0 and inflight <= 0.
  - ins <= 0 and ins_pc <= 0.
  - Reset asserted mid-operation discards all queued and in-flight words identically.

## Timing
- Reset values during and after rst: imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins=0, ins_pc=0.
- First cycle after rst deasserts (C0): imem_req=1 with imem_addr=RESET_PC. Data returns in C1; ins_valid=1 with that word in C2.
- Fetch-to-decode latency: 2 cycles from request to ins_valid.
- Throughput: one instruction per cycle while ins_ready=1.
- Back-pressure (ins_ready=0): at most 2 requests issue, then imem_req stays 0. Issue resumes in the same cycle that ins_ready returns high.
- After a redirect in cycle R:
  - First request at redirect_pc in R+1.
  - ins_valid=0 through R+2.
  - New instruction valid in R+3.

## Test plan
- Reset release, ins_ready=1, memory returns addr^32'hA5A5_0000 -> ins_pc 0,4,8,… one per cycle from C2; ins matches; no gaps.
- ins_ready low for 5 cycles after C2 -> exactly 2 outstanding (occ=2, imem_req=0). After release, ins_pc continues 4,8,… with no loss or duplication.
- redirect with redirect_pc=32'h0000_0103 while occ=1 and inflight=1 -> both words dropped; next imem_addr=32'h0000_0100; first valid ins_pc=0x100 at R+3.
- redirect asserted in the same cycle as ins_valid & ins_ready -> that word is not counted as transferred; ins_valid=0 next cycle.
- RESET_PC=32'hFFFF_FFF8 -> ins_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst pulsed for 1 cycle with occ=2 -> ins_valid=0 next cycle; stale imem_rdata ignored; fetch restarts at RESET_PC.
